id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: id_valid  input  1  ID holds a valid instruction.
REQ-004 SHALL: id_ready  output  1  ID/EX accepts the ID instruction this cycle; 0 = hold IF/ID.
REQ-005 SHALL: id_rn, id_rm, id_rd  input  5 each  source and destination register numbers.
REQ-006 SHALL: id_rd1, id_rd2  input  64 each  ReadData1/ReadData2 from the register file for id_rn/id_rm.
REQ-007 SHALL: id_imm  input  64  sign-extended immediate; id_ctrl  input  ctrl_t  decoded control.
REQ-008 SHALL: flush  input  1  squash the instruction entering ID/EX (branch taken).
REQ-009 SHALL: exm_reg_write, exm_rd, exm_result  input  1/5/64  EX/MEM producer.
REQ-010 SHALL: mwb_reg_write, mwb_rd, mwb_data  input  1/5/64  MEM/WB producer (same signals drive regfile write).
REQ-011 SHALL: ex_valid, ex_rd, ex_ctrl, ex_imm  output  1/5/ctrl_t/64  registered ID/EX contents.
REQ-012 SHALL: ex_opA, ex_opB  output  64 each  resolved EX operands.

Function
REQ-013 SHALL: hazard = id_valid & ex_valid & ex_ctrl.mem_read & ex_rd!=31 & (ex_rd==id_rn | ex_rd==id_rm) (load-use).
REQ-014 SHALL: id_ready = ~hazard | flush; id_ready has no dependence on exm_*/mwb_* when FORWARDING_EN is defined.
REQ-015 SHALL: on edge with flush=1, ID/EX loads a bubble (ex_valid=0, ex_ctrl all-zero) regardless of hazard.
REQ-016 SHALL: on edge with hazard=1 and flush=0, ID/EX loads a bubble; IF/ID holds (id_ready=0).
REQ-017 SHALL: otherwise ID/EX captures id_valid, id_rn, id_rm, id_rd, id_imm, id_ctrl (ctrl zeroed if id_valid=0), and operands.
REQ-018 SHALL: write-through capture: if mwb_reg_write & mwb_rd!=31 & mwb_rd==id_rn, latch mwb_data as operand A, else id_rd1; same for id_rm/operand B.
REQ-019 SHALL: ex_opA combinational from latched state: exm match -> exm_result; else mwb match -> mwb_data; else latched A; same for ex_opB with rm.
REQ-020 SHALL: a match requires producer reg_write=1, producer rd==latched source, rd!=31 and ex_valid=1; EX/MEM has priority over MEM/WB.
REQ-021 SHALL: register 31 reads as 64'h0 on ex_opA/ex_opB regardless of latched or forwarded values.
REQ-022 SHALL: latency ID -> EX outputs is exactly one cycle when not stalled.

Reset
REQ-023 SHALL: reset=1 at an edge forces ex_valid=0, ex_ctrl=0, ex_rd=31, latched operands/ex_imm=0; overrides flush and hazard.
REQ-024 SHALL: while reset=1, id_ready=1; ex_opA/ex_opB read 0.
REQ-025 SHALL: reset mid-stall discards the stalled instruction's bubble state; first edge after release captures ID normally.

Configuration
REQ-026 SHALL: macro FORWARDING_EN defined -> REQ-019 bypass present, stalls only per REQ-013.
REQ-027 SHALL: FORWARDING_EN undefined -> ex_opA/ex_opB = latched operands (with REQ-021); hazard additionally asserts when an ID source (!=31) equals ex_rd with ex_ctrl.reg_write & ex_valid, or equals exm_rd with exm_reg_write; REQ-018 remains.

Structure
REQ-028 SHALL: shared package cpu_pkg holds ctrl_t (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[3:0]), XZR=5'd31, DATA_LENGTH=64.
REQ-029 SHALL: one sub-module fwd_sel, instantiated per operand, implements REQ-019..021 priority select.

Verification
REQ-030 SHALL: reset 1 cycle -> ex_valid=0, ex_ctrl=0, ex_opA=ex_opB=0, id_ready=1.
REQ-031 SHALL: ID/EX holds ADD rn=1 latched A=5; exm_reg_write=1 exm_rd=1 exm_result=0xA0, mwb_rd=1 mwb_data=0xB0 -> ex_opA=0xA0 (FORWARDING_EN).
REQ-032 SHALL: ex holds LDUR rd=2 mem_read=1; ID ADD rn=2 -> id_ready=0 one cycle, next ex_valid=0, following edge ADD captured.
REQ-033 SHALL: ID rm=3 id_rd2=7 while mwb_reg_write=1 mwb_rd=3 mwb_data=0x55 -> next cycle latched B=0x55, ex_opB=0x55 with no producers.
REQ-034 SHALL: exm_reg_write=1 exm_rd=31 exm_result=0xA0, ex rn=31 -> ex_opA=0.
REQ-035 SHALL: flush=1 coincident with load-use hazard -> id_ready=1, next ex_valid=0, ex_ctrl=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: decoded control word, zero-register
// number and datapath width, plus a small producer-match helper used by
// both hazard detection and operand selection.
package cpu_pkg;

    localparam int         DATA_LENGTH = 64;
    localparam logic [4:0] XZR         = 5'd31;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A producer matches a source when it writes a real register (never XZR)
    // whose number equals the source.
    function automatic logic src_match(input logic       rw,
                                       input logic [4:0] prod_rd,
                                       input logic [4:0] src);
        return rw && (prod_rd != XZR) && (prod_rd == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand EX source select. XZR always reads zero; otherwise EX/MEM
// wins over MEM/WB, and the ID/EX latched value is the fallback. With
// FWD_EN=0 only the latched value (and the XZR rule) is used.
module fwd_sel
    import cpu_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic                   ex_valid,
    input  logic [4:0]             src,
    input  logic [DATA_LENGTH-1:0] latched,
    input  logic                   exm_reg_write,
    input  logic [4:0]             exm_rd,
    input  logic [DATA_LENGTH-1:0] exm_result,
    input  logic                   mwb_reg_write,
    input  logic [4:0]             mwb_rd,
    input  logic [DATA_LENGTH-1:0] mwb_data,
    output logic [DATA_LENGTH-1:0] operand
);

    logic exm_hit;
    logic mwb_hit;

    // producer hits only count for a live instruction in EX
    always_comb begin
        exm_hit = FWD_EN && ex_valid && src_match(exm_reg_write, exm_rd, src);
        mwb_hit = FWD_EN && ex_valid && src_match(mwb_reg_write, mwb_rd, src);
    end

    // priority select: zero register, then newest producer, then latched
    always_comb begin
        operand = latched;
        if (src == XZR) begin
            operand = '0;
        end else if (exm_hit) begin
            operand = exm_result;
        end else if (mwb_hit) begin
            operand = mwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, register-file
// write-through capture and EX operand resolution.
// Build option: define FORWARDING_EN to enable the EX/MEM and MEM/WB bypass.
// Without it, operands come only from the latched values and any RAW
// dependence on the instruction in EX or EX/MEM stalls ID instead.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [4:0]             id_rn,
    input  logic [4:0]             id_rm,
    input  logic [4:0]             id_rd,
    input  logic [DATA_LENGTH-1:0] id_rd1,
    input  logic [DATA_LENGTH-1:0] id_rd2,
    input  logic [DATA_LENGTH-1:0] id_imm,
    input  ctrl_t                  id_ctrl,
    input  logic                   flush,
    input  logic                   exm_reg_write,
    input  logic [4:0]             exm_rd,
    input  logic [DATA_LENGTH-1:0] exm_result,
    input  logic                   mwb_reg_write,
    input  logic [4:0]             mwb_rd,
    input  logic [DATA_LENGTH-1:0] mwb_data,
    output logic                   ex_valid,
    output logic [4:0]             ex_rd,
    output ctrl_t                  ex_ctrl,
    output logic [DATA_LENGTH-1:0] ex_imm,
    output logic [DATA_LENGTH-1:0] ex_opA,
    output logic [DATA_LENGTH-1:0] ex_opB
);

`ifdef FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [4:0]             ex_rn;
    logic [4:0]             ex_rm;
    logic [DATA_LENGTH-1:0] lat_a;
    logic [DATA_LENGTH-1:0] lat_b;

    logic                   load_use;
    logic                   raw_hz;
    logic                   hazard;
    logic [DATA_LENGTH-1:0] cap_a;
    logic [DATA_LENGTH-1:0] cap_b;
    logic [DATA_LENGTH-1:0] sel_a;
    logic [DATA_LENGTH-1:0] sel_b;

    // load in EX whose destination feeds the instruction in ID
    always_comb begin
        load_use = id_valid && ex_valid && ex_ctrl.mem_read && (ex_rd != XZR)
                   && ((ex_rd == id_rn) || (ex_rd == id_rm));
    end

    // without a bypass every in-flight RAW dependence must wait it out;
    // MEM/WB needs no stall because write-through capture covers it
    always_comb begin
        raw_hz = 1'b0;
        if (!FWD_EN && id_valid) begin
            raw_hz = src_match(ex_valid && ex_ctrl.reg_write, ex_rd, id_rn)
                  || src_match(ex_valid && ex_ctrl.reg_write, ex_rd, id_rm)
                  || src_match(exm_reg_write, exm_rd, id_rn)
                  || src_match(exm_reg_write, exm_rd, id_rm);
        end
    end

    // stall decision and handshake back to IF/ID
    always_comb begin
        hazard   = load_use || raw_hz;
        id_ready = reset || flush || !hazard;
    end

    // register-file write happening this cycle is not yet visible on rd1/rd2
    always_comb begin
        cap_a = src_match(mwb_reg_write, mwb_rd, id_rn) ? mwb_data : id_rd1;
        cap_b = src_match(mwb_reg_write, mwb_rd, id_rm) ? mwb_data : id_rd2;
    end

    // ID/EX register: reset, bubble on flush or stall, else capture ID
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            ex_rd    <= XZR;
            ex_rn    <= XZR;
            ex_rm    <= XZR;
            ex_imm   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
        end else if (flush || hazard) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            ex_rd    <= XZR;
            ex_rn    <= XZR;
            ex_rm    <= XZR;
            ex_imm   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
            ex_rd    <= id_rd;
            ex_rn    <= id_rn;
            ex_rm    <= id_rm;
            ex_imm   <= id_imm;
            lat_a    <= cap_a;
            lat_b    <= cap_b;
        end
    end

    fwd_sel #(.FWD_EN(FWD_EN)) u_sel_a (
        .ex_valid      (ex_valid),
        .src           (ex_rn),
        .latched       (lat_a),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_data      (mwb_data),
        .operand       (sel_a)
    );

    fwd_sel #(.FWD_EN(FWD_EN)) u_sel_b (
        .ex_valid      (ex_valid),
        .src           (ex_rm),
        .latched       (lat_b),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_data      (mwb_data),
        .operand       (sel_b)
    );

    // operands read zero while reset is held, before the register settles
    always_comb begin
        ex_opA = reset ? '0 : sel_a;
        ex_opB = reset ? '0 : sel_b;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage with a rule-level reference model.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready, flush;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic [63:0] id_rd1, id_rd2, id_imm;
    ctrl_t       id_ctrl;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [63:0] exm_result, mwb_data;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    ctrl_t       ex_ctrl;
    logic [63:0] ex_imm, ex_opA, ex_opB;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm),
        .ex_opA(ex_opA), .ex_opB(ex_opB)
    );

    typedef struct {
        bit valid; bit [4:0] rn, rm, rd; bit [63:0] rd1, rd2, imm; ctrl_t ctrl; bit flush;
        bit exm_rw; bit [4:0] exm_rd; bit [63:0] exm_res;
        bit mwb_rw; bit [4:0] mwb_rd; bit [63:0] mwb_data;
    } vec_t;

    // the instruction the model believes is sitting in EX
    typedef struct {
        bit valid; bit [4:0] rn, rm, rd; bit [63:0] a, b, imm; ctrl_t ctrl;
    } ex_model_t;
    ex_model_t m;

    function automatic ctrl_t mkc(bit rw, bit mr, bit mw, bit m2r, bit as, bit [3:0] op);
        ctrl_t c;
        c.reg_write = rw; c.mem_read = mr; c.mem_write = mw;
        c.mem_to_reg = m2r; c.alu_src = as; c.alu_op = op;
        return c;
    endfunction

    function automatic vec_t mkv(bit v, bit [4:0] rn, bit [4:0] rm, bit [4:0] rd,
                                 bit [63:0] rd1, bit [63:0] rd2, bit [63:0] imm, ctrl_t c,
                                 bit fl, bit erw, bit [4:0] erd, bit [63:0] eres,
                                 bit mrw, bit [4:0] mrd, bit [63:0] mdat);
        vec_t x;
        x.valid = v; x.rn = rn; x.rm = rm; x.rd = rd; x.rd1 = rd1; x.rd2 = rd2;
        x.imm = imm; x.ctrl = c; x.flush = fl; x.exm_rw = erw; x.exm_rd = erd;
        x.exm_res = eres; x.mwb_rw = mrw; x.mwb_rd = mrd; x.mwb_data = mdat;
        return x;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rn = v.rn; id_rm = v.rm; id_rd = v.rd;
        id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm; id_ctrl = v.ctrl; flush = v.flush;
        exm_reg_write = v.exm_rw; exm_rd = v.exm_rd; exm_result = v.exm_res;
        mwb_reg_write = v.mwb_rw; mwb_rd = v.mwb_rd; mwb_data = v.mwb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // stall rule: load-use always; without bypass also any RAW on EX or EX/MEM
    function automatic bit exp_hazard();
        bit h;
        h = id_valid && m.valid && m.ctrl.mem_read && (m.rd != 5'd31)
            && (m.rd == id_rn || m.rd == id_rm);
`ifndef FORWARDING_EN
        if (id_valid) begin
            if (id_rn != 5'd31 && ((m.valid && m.ctrl.reg_write && m.rd == id_rn) ||
                                   (exm_reg_write && exm_rd == id_rn))) h = 1;
            if (id_rm != 5'd31 && ((m.valid && m.ctrl.reg_write && m.rd == id_rm) ||
                                   (exm_reg_write && exm_rd == id_rm))) h = 1;
        end
`endif
        return h;
    endfunction

    function automatic bit [63:0] exp_op(input bit [4:0] src, input bit [63:0] lat);
        if (reset || src == 5'd31) return 64'h0;
`ifdef FORWARDING_EN
        if (m.valid && exm_reg_write && exm_rd == src) return exm_result;
        if (m.valid && mwb_reg_write && mwb_rd == src) return mwb_data;
`endif
        return lat;
    endfunction

    function automatic bit [63:0] wt(input bit [4:0] src, input bit [63:0] rf);
        if (mwb_reg_write && mwb_rd != 5'd31 && mwb_rd == src) return mwb_data;
        return rf;
    endfunction

    // model update on each clock edge
    always @(posedge clk) begin
        if (reset) begin
            m.valid = 0; m.ctrl = '0; started = 1;
        end else if (flush || exp_hazard()) begin
            m.valid = 0; m.ctrl = '0;
        end else begin
            m.valid = id_valid;
            m.ctrl  = id_valid ? id_ctrl : '0;
            m.rn = id_rn; m.rm = id_rm; m.rd = id_rd; m.imm = id_imm;
            m.a  = wt(id_rn, id_rd1);
            m.b  = wt(id_rm, id_rd2);
        end
    end

    // continuous comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (started) begin
            chk("m_id_ready", {63'h0, id_ready}, {63'h0, reset || flush || !exp_hazard()});
            chk("m_ex_valid", {63'h0, ex_valid}, {63'h0, m.valid});
            chk("m_ex_ctrl", {55'h0, ex_ctrl}, {55'h0, m.ctrl});
            if (reset) begin
                chk("m_opA_rst", ex_opA, 64'h0);
                chk("m_opB_rst", ex_opB, 64'h0);
            end else if (m.valid) begin
                chk("m_ex_rd", {59'h0, ex_rd}, {59'h0, m.rd});
                chk("m_ex_imm", ex_imm, m.imm);
                chk("m_opA", ex_opA, exp_op(m.rn, m.a));
                chk("m_opB", ex_opB, exp_op(m.rm, m.b));
            end
        end
    end

    ctrl_t ADD, LDUR, SUB, STUR;
    vec_t  idle;
    vec_t  tbl [6];

    initial begin
        ADD  = mkc(1, 0, 0, 0, 0, 4'b0010);
        SUB  = mkc(1, 0, 0, 0, 0, 4'b0110);
        LDUR = mkc(1, 1, 0, 1, 1, 4'b0010);
        STUR = mkc(0, 0, 1, 0, 1, 4'b0010);
        idle = mkv(0, 31, 31, 31, 0, 0, 0, '0, 0, 0, 31, 0, 0, 31, 0);

        // reset
        reset = 1;
        drive(mkv(1, 2, 2, 4, 1, 1, 0, ADD, 0, 0, 31, 0, 0, 31, 0));
        tick();
        drive(idle);
        #1;
        chk("rst_ex_valid", {63'h0, ex_valid}, 64'h0);
        chk("rst_ex_ctrl", {55'h0, ex_ctrl}, 64'h0);
        chk("rst_ex_rd", {59'h0, ex_rd}, 64'd31);
        chk("rst_opA", ex_opA, 64'h0);
        chk("rst_opB", ex_opB, 64'h0);
        chk("rst_id_ready", {63'h0, id_ready}, 64'h1);
        tick();
        reset = 0;

        // write-through capture of operand B
        drive(mkv(1, 4, 3, 5, 64'h11, 64'h7, 64'h20, ADD, 0, 0, 31, 0, 1, 3, 64'h55));
        tick();
        drive(idle);
        #1;
        chk("wt_opB", ex_opB, 64'h55);
        chk("wt_opA", ex_opA, 64'h11);
        chk("wt_imm", ex_imm, 64'h20);
        chk("wt_rd", {59'h0, ex_rd}, 64'd5);

        // EX/MEM over MEM/WB priority, then MEM/WB alone
        drive(mkv(1, 1, 6, 7, 64'h5, 64'h9, 0, ADD, 0, 0, 31, 0, 0, 31, 0));
        tick();
        drive(mkv(0, 31, 31, 31, 0, 0, 0, '0, 0, 1, 1, 64'hA0, 1, 1, 64'hB0));
        #1;
`ifdef FORWARDING_EN
        chk("fwd_exm_prio", ex_opA, 64'hA0);
`else
        chk("nofwd_latched", ex_opA, 64'h5);
`endif
        drive(mkv(0, 31, 31, 31, 0, 0, 0, '0, 0, 0, 31, 0, 1, 1, 64'hB0));
        #1;
`ifdef FORWARDING_EN
        chk("fwd_mwb", ex_opA, 64'hB0);
`else
        chk("nofwd_latched2", ex_opA, 64'h5);
`endif
        chk("nomatch_opB", ex_opB, 64'h9);
        tick();

        // load-use stall
        drive(mkv(1, 7, 31, 2, 0, 0, 64'h8, LDUR, 0, 0, 31, 0, 0, 31, 0));
        tick();
        drive(mkv(1, 2, 8, 9, 64'h3, 64'h4, 0, ADD, 0, 0, 31, 0, 0, 31, 0));
        #1;
        chk("lu_stall", {63'h0, id_ready}, 64'h0);
        tick();
        #1;
        chk("lu_bubble", {63'h0, ex_valid}, 64'h0);
        chk("lu_release", {63'h0, id_ready}, 64'h1);
        tick();
        drive(idle);
        #1;
        chk("lu_capture_v", {63'h0, ex_valid}, 64'h1);
        chk("lu_capture_rd", {59'h0, ex_rd}, 64'd9);
        chk("lu_capture_a", ex_opA, 64'h3);

        // flush overrides hazard
        drive(mkv(1, 7, 31, 2, 0, 0, 0, LDUR, 0, 0, 31, 0, 0, 31, 0));
        tick();
        drive(mkv(1, 8, 2, 9, 0, 0, 0, ADD, 1, 0, 31, 0, 0, 31, 0));
        #1;
        chk("flush_ready", {63'h0, id_ready}, 64'h1);
        tick();
        drive(idle);
        #1;
        chk("flush_valid", {63'h0, ex_valid}, 64'h0);
        chk("flush_ctrl", {55'h0, ex_ctrl}, 64'h0);

        // zero register never forwarded
        drive(mkv(1, 31, 31, 6, 64'h77, 64'h88, 0, ADD, 0, 0, 31, 0, 1, 31, 64'h99));
        tick();
        drive(mkv(0, 31, 31, 31, 0, 0, 0, '0, 0, 1, 31, 64'hA0, 1, 31, 64'hB0));
        #1;
        chk("xzr_opA", ex_opA, 64'h0);
        chk("xzr_opB", ex_opB, 64'h0);
        tick();

        // reset in the middle of a stall
        drive(mkv(1, 7, 31, 2, 0, 0, 0, LDUR, 0, 0, 31, 0, 0, 31, 0));
        tick();
        drive(mkv(1, 2, 9, 3, 64'h42, 64'h43, 0, ADD, 0, 0, 31, 0, 0, 31, 0));
        reset = 1;
        #1;
        chk("rs_ready", {63'h0, id_ready}, 64'h1);
        chk("rs_opA", ex_opA, 64'h0);
        tick();
        #1;
        chk("rs_valid", {63'h0, ex_valid}, 64'h0);
        reset = 0;
        tick();
        #1;
        chk("rs_cap_v", {63'h0, ex_valid}, 64'h1);
        chk("rs_cap_rd", {59'h0, ex_rd}, 64'd3);
        chk("rs_cap_a", ex_opA, 64'h42);

        // plain RAW on an ALU result: stall only without bypass
        drive(mkv(1, 10, 11, 4, 0, 0, 0, ADD, 0, 0, 31, 0, 0, 31, 0));
        tick();
        drive(mkv(1, 4, 12, 5, 0, 0, 0, SUB, 0, 0, 31, 0, 0, 31, 0));
        #1;
`ifdef FORWARDING_EN
        chk("raw_ready", {63'h0, id_ready}, 64'h1);
`else
        chk("raw_ready", {63'h0, id_ready}, 64'h0);
`endif
        tick();
        drive(idle);
        tick();

        // directed sweep checked against the model
        tbl[0] = mkv(1, 5, 6, 7, 64'h1000, 64'h2000, 64'h8, ADD, 0, 0, 31, 0, 0, 31, 0);
        tbl[1] = mkv(1, 7, 5, 8, 64'h10, 64'h20, 64'h4, ADD, 0, 1, 7, 64'h333, 0, 31, 0);
        tbl[2] = mkv(0, 1, 2, 3, 64'h1, 64'h2, 64'h3, ADD, 0, 0, 31, 0, 0, 31, 0);
        tbl[3] = mkv(1, 2, 3, 31, 64'h5, 64'h6, 64'h10, STUR, 0, 0, 31, 0, 1, 2, 64'hDEAD);
        tbl[4] = mkv(1, 3, 3, 3, 64'h7, 64'h7, 0, ADD, 0, 1, 3, 64'h44, 1, 3, 64'h55);
        tbl[5] = mkv(0, 31, 31, 31, 0, 0, 0, '0, 0, 1, 3, 64'h66, 1, 2, 64'h77);
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            tick();
        end
        drive(idle);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
